// File: rtl/blink_monitor.sv
// Purpose : measures high/low durations of an async blink input and checks each period against expected on/off times.
// Latency : sig_in edge to internal edge detect is 2-3 clk; period_valid/in_spec/len outputs register 1 clk after that.
// Backpressure: none; free-running monitor, period_valid is a 1-cycle pulse with no handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sig_in       asynchronous blink input
//   level        synchronized sig_in (second synchronizer stage)
//   high_len     last completed high duration in clk cycles
//   low_len      last completed low duration in clk cycles
//   period_valid 1-cycle pulse when a full high-then-low period has been captured
//   in_spec      last captured period within +/-TOL of expected; updated with period_valid
//   stuck        no edge for TIMEOUT cycles; held until the next edge
module blink_monitor #(
    parameter int CNT_W    = 32,
    parameter int EXP_HIGH = 25000000,
    parameter int EXP_LOW  = 25000000,
    parameter int TOL      = 1000,
    parameter int TIMEOUT  = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             level,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             period_valid,
    output logic             in_spec,
    output logic             stuck
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_STUCK
    } state_t;

    // Tolerance math is done one bit wider than the counters so the
    // subtraction can never wrap.
    localparam logic [CNT_W:0]   EH  = (CNT_W+1)'(EXP_HIGH);
    localparam logic [CNT_W:0]   EL  = (CNT_W+1)'(EXP_LOW);
    localparam logic [CNT_W:0]   TL  = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic             sync1;
    logic             prev;
    logic             have_high;
    logic [CNT_W-1:0] cnt;

    logic             rise;
    logic             fall;
    logic             tmo_hit;

    logic [CNT_W:0]   hl_ext;
    logic [CNT_W:0]   ll_ext;
    logic [CNT_W:0]   dev_h;
    logic [CNT_W:0]   dev_l;
    logic             period_ok;

    assign rise    = level & ~prev;
    assign fall    = ~level & prev;
    assign tmo_hit = (cnt == TMO);

    // Evaluated on the rise that closes a period: high_len already holds the
    // captured high time, cnt is the low time being captured this cycle.
    always_comb begin
        hl_ext    = {1'b0, high_len};
        ll_ext    = {1'b0, cnt};
        dev_h     = (hl_ext >= EH) ? (hl_ext - EH) : (EH - hl_ext);
        dev_l     = (ll_ext >= EL) ? (ll_ext - EL) : (EL - ll_ext);
        period_ok = (dev_h <= TL) && (dev_l <= TL);
    end

    // Synchronizer, edge history and duration counter. The counter restarts
    // at 1 on every edge so a level lasting N cycles reads N on the edge
    // that ends it; it saturates at TIMEOUT so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= sig_in;
            level <= sync1;
            prev  <= level;
            if (rise || fall) begin
                cnt <= ONE;
            end else if (!tmo_hit) begin
                cnt <= cnt + ONE;
            end
        end
    end

    // Measurement FSM. An edge always takes priority over the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            have_high    <= 1'b0;
            high_len     <= '0;
            low_len      <= '0;
            period_valid <= 1'b0;
            in_spec      <= 1'b0;
            stuck        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                // Level before the first edge is of unknown length: discard it.
                S_IDLE: begin
                    if (rise) begin
                        state <= S_HIGH;
                    end else if (fall) begin
                        state <= S_LOW;
                    end else if (tmo_hit) begin
                        state     <= S_STUCK;
                        stuck     <= 1'b1;
                        have_high <= 1'b0;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        high_len  <= cnt;
                        have_high <= 1'b1;
                        state     <= S_LOW;
                    end else if (tmo_hit) begin
                        state     <= S_STUCK;
                        stuck     <= 1'b1;
                        have_high <= 1'b0;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        low_len <= cnt;
                        state   <= S_HIGH;
                        // Only a genuinely measured high makes a full period.
                        if (have_high) begin
                            period_valid <= 1'b1;
                            in_spec      <= period_ok;
                        end
                    end else if (tmo_hit) begin
                        state     <= S_STUCK;
                        stuck     <= 1'b1;
                        have_high <= 1'b0;
                    end
                end
                // Leaving STUCK: the stuck level's length is meaningless, so
                // it is not captured; the next level starts a fresh measurement.
                S_STUCK: begin
                    if (rise) begin
                        state <= S_HIGH;
                        stuck <= 1'b0;
                    end else if (fall) begin
                        state <= S_LOW;
                        stuck <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
